// File: rtl/led_anim_pkg.sv
// led_anim_pkg: shared mode encodings, blank pattern and FSM state type for the LED animation sequencer
package led_anim_pkg;
    localparam logic [1:0] MODE_FWD      = 2'b00;
    localparam logic [1:0] MODE_PINGPONG = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;
    localparam logic [6:0] SEG_BLANK     = 7'h7F;
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/led_anim_rom.sv
// led_anim_rom: combinational per-digit, per-frame active-low segment pattern table
module led_anim_rom
    import led_anim_pkg::*;
#(
    parameter int DIG_W   = 2,
    parameter int FRAME_W = 5
) (
    input  logic [DIG_W-1:0]   digit_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic [6:0]         seg_o
);
    // only digit 0, frames 6..13 carry the animation; everything else is dark
    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i == '0) begin
            case (32'(frame_i))
                6:       seg_o = 7'h3F;
                7:       seg_o = 7'h39;
                8:       seg_o = 7'h30;
                9:       seg_o = 7'h30;
                10:      seg_o = 7'h30;
                11:      seg_o = 7'h30;
                12:      seg_o = 7'h70;
                13:      seg_o = 7'h76;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/led_anim_seq.sv
// led_anim_seq: frame sequencer with programmable rate and multiplexed 7-segment scan; ping-pong enabled by LED_ANIM_PINGPONG_EN
module led_anim_seq
    import led_anim_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int FRAMES   = 32,
    parameter int FRAME_W  = $clog2(FRAMES),
    parameter int DIV_W    = 24,
    parameter int SCAN_DIV = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   speed,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  an,
    output logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               done
);
    localparam int DIG_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int SC_W  = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic               done_q, done_d;
    logic [SC_W-1:0]    sc_q, sc_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic               tick, last, first;
`ifdef LED_ANIM_PINGPONG_EN
    logic               dir_q, dir_d;
`endif

    assign tick  = (state_q == RUN) && (pre_q >= speed);
    assign last  = frame_q == FRAME_W'(FRAMES - 1);
    assign first = frame_q == '0;

    // run control: start/stop/restart handling, prescaler and per-tick frame stepping
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
        dir_d   = dir_q;
`endif
        if (state_q == IDLE) begin
            pre_d = '0;
            if (start && !stop) begin
                state_d = RUN;
                frame_d = '0;
`ifdef LED_ANIM_PINGPONG_EN
                dir_d   = 1'b1;
`endif
            end
        end else if (stop) begin
            state_d = IDLE;
            pre_d   = '0;
        end else if (start) begin
            frame_d = '0;
            pre_d   = '0;
`ifdef LED_ANIM_PINGPONG_EN
            dir_d   = 1'b1;
`endif
        end else if (tick) begin
            pre_d = '0;
            if (mode == MODE_ONESHOT) begin
                if (last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
`ifdef LED_ANIM_PINGPONG_EN
            end else if (mode == MODE_PINGPONG) begin
                if (dir_q) begin
                    frame_d = last ? frame_q - 1'b1 : frame_q + 1'b1;
                    dir_d   = !last;
                end else begin
                    frame_d = first ? frame_q + 1'b1 : frame_q - 1'b1;
                    dir_d   = first;
                end
`endif
            end else begin
                frame_d = last ? '0 : frame_q + 1'b1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // free-running digit scan; display registers follow current digit and frame together
    always_comb begin
        sc_d = (sc_q == SC_W'(SCAN_DIV - 1)) ? '0 : sc_q + 1'b1;
        dig_d = (sc_q != SC_W'(SCAN_DIV - 1)) ? dig_q : (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        an_d = ~(DIGITS'(1) << dig_q);
    end

    led_anim_rom #(.DIG_W(DIG_W), .FRAME_W(FRAME_W)) u_rom (
        .digit_i (dig_q),
        .frame_i (frame_q),
        .seg_o   (seg_d)
    );

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
            sc_q    <= '0;
            dig_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
            sc_q    <= sc_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

`ifdef LED_ANIM_PINGPONG_EN
    // ping-pong direction, 1 = counting up
    always_ff @(posedge clk) begin
        if (rst) dir_q <= 1'b1;
        else     dir_q <= dir_d;
    end
`endif

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;
    assign busy  = state_q == RUN;
    assign done  = done_q;
endmodule

// File: tb/tb_led_anim_seq.sv
// tb_led_anim_seq: scoreboard bench with a behavioural model of the LED animation sequencer
module tb_led_anim_seq;
    localparam int DIGITS   = 4;
    localparam int FRAMES   = 32;
    localparam int FRAME_W  = 5;
    localparam int DIV_W    = 8;
    localparam int SCAN_DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [DIV_W-1:0] speed = '0;
    logic [6:0] seg;
    logic [DIGITS-1:0] an;
    logic [FRAME_W-1:0] frame;
    logic busy, done;

    typedef struct {
        int frame;
        int busy;
        int done;
        int seg;
        int an;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int m_run, m_frame, m_dir, m_el, m_n;

    always #5 clk = ~clk;

    led_anim_seq #(
        .DIGITS(DIGITS), .FRAMES(FRAMES), .FRAME_W(FRAME_W), .DIV_W(DIV_W), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .speed(speed),
        .seg(seg), .an(an), .frame(frame), .busy(busy), .done(done)
    );

    function automatic int pat(int d, int f);
        int tab [0:7];
        tab = '{'h3F, 'h39, 'h30, 'h30, 'h30, 'h30, 'h70, 'h76};
        return (d == 0 && f >= 6 && f <= 13) ? tab[f-6] : 'h7F;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", n, $time, a, x);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p, input int md, input int sp);
        exp_t e;
        int d, m;
        @(negedge clk);
        rst = r; start = s; stop = p; mode = 2'(md); speed = DIV_W'(sp);
        m = (md == 3) ? 0 : md;
        e.done = 0;
        if (r) begin
            m_run = 0; m_frame = 0; m_dir = 1; m_el = 0; m_n = 0;
            e.seg = 'h7F;
            e.an = (1 << DIGITS) - 1;
        end else begin
            d = (m_n / SCAN_DIV) % DIGITS;
            e.seg = pat(d, m_frame);
            e.an = ((1 << DIGITS) - 1) & ~(1 << d);
            m_n++;
            if (!m_run) begin
                m_el = 0;
                if (s && !p) begin m_run = 1; m_frame = 0; m_dir = 1; end
            end else if (p) begin
                m_run = 0;
            end else if (s) begin
                m_frame = 0; m_dir = 1; m_el = 0;
            end else if (m_el >= sp) begin
                m_el = 0;
                if (m == 2) begin
                    if (m_frame == FRAMES - 1) begin m_run = 0; e.done = 1; end
                    else m_frame++;
                end
`ifdef LED_ANIM_PINGPONG_EN
                else if (m == 1) begin
                    if (m_frame + m_dir < 0 || m_frame + m_dir > FRAMES - 1) m_dir = -m_dir;
                    m_frame += m_dir;
                end
`endif
                else m_frame = (m_frame + 1) % FRAMES;
            end else begin
                m_el++;
            end
        end
        e.frame = m_frame;
        e.busy = m_run;
        q.push_back(e);
    endtask

    task automatic run(input int n, input int md, input int sp);
        for (int i = 0; i < n; i++) step(0, 0, 0, md, sp);
    endtask

    // monitor: pops one expectation per clock, just after the edge it describes
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("frame", 32'(frame), e.frame);
                chk("busy", 32'(busy), e.busy);
                chk("done", 32'(done), e.done);
                chk("seg", 32'(seg), e.seg);
                chk("an", 32'(an), e.an);
            end
        end
    end

    initial begin
        int md, sp;
        repeat (3) step(1, 0, 0, 0, 0);
        run(4, 0, 3);
        step(0, 1, 0, 0, 3);
        run(130, 0, 3);
        step(0, 1, 0, 1, 0);
        run(70, 1, 0);
        step(0, 1, 0, 2, 1);
        run(70, 2, 1);
        step(0, 1, 0, 0, 2);
        run(10, 0, 2);
        step(0, 1, 1, 0, 2);
        run(5, 0, 2);
        step(0, 1, 0, 0, 2);
        run(10, 0, 2);
        step(0, 1, 0, 0, 10);
        run(7, 0, 10);
        run(8, 0, 2);
        step(0, 1, 0, 1, 0);
        run(35, 1, 0);
        run(5, 0, 0);
        run(10, 1, 0);
        step(1, 0, 0, 1, 0);
        run(3, 1, 0);
        step(0, 1, 0, 0, 0);
        run(7, 0, 0);
        step(0, 0, 1, 0, 0);
        run(16, 0, 0);
        md = 0; sp = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) md = $urandom_range(3);
            if ($urandom_range(49) == 0) sp = $urandom_range(5);
            step($urandom_range(499) == 0, $urandom_range(39) == 0, $urandom_range(59) == 0, md, sp);
        end
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
